// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive front-end.
// Holds the FSM state encoding and the saturating increment helper.
package i2s_pkg;

   typedef enum logic [1:0] {PRIME, HUNT, SHIFT, PAD} state_t;

   localparam int FMT_I2S = 0;
   localparam int FMT_LJ  = 1;

   localparam logic CH_LEFT  = 1'b0;
   localparam logic CH_RIGHT = 1'b1;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] max
   );
      return (v >= max) ? max : v + 32'd1;
   endfunction

endpackage

// File: rtl/i2s_rx_frontend.sv
// Bit-level I2S receiver: LRCLK framing, MSB-first deserialisation,
// toggle-flagged word hand-off and short-word error accounting.
module i2s_rx_frontend
   import i2s_pkg::*;
#(
   parameter int I2S_WIDTH = 24,
   parameter int FORMAT    = FMT_I2S,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i2s_bclk,
   input  logic                 sys_rst,
   input  logic                 i2s_lrclk,
   input  logic                 i2s_data,
   output logic [I2S_WIDTH-1:0] rx_data,
   output logic                 rx_ch,
   output logic                 rx_valid,
   output logic                 rx_toggle,
   output logic                 word_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 locked
);

   localparam int CW = $clog2(I2S_WIDTH + 1);
   localparam logic LJ = (FORMAT == FMT_LJ);
   localparam logic [CW-1:0] LAST = CW'(I2S_WIDTH);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   state_t               state_q;
   state_t               state_d;
   logic                 lrclk_q;
   logic                 ch_q;
   logic [I2S_WIDTH-2:0] sh_q;
   logic [CW-1:0]        cnt_q;
   logic [CW-1:0]        cnt_inc;
   logic [I2S_WIDTH-1:0] sh_in;
   logic                 edge_det;
   logic                 last;
   logic                 start;
   logic                 done;
   logic                 short_w;
   logic                 shift_en;

   assign edge_det = (state_q != PRIME) && (i2s_lrclk != lrclk_q);
   assign sh_in    = {sh_q, i2s_data};
   assign cnt_inc  = cnt_q + 1'b1;
   assign last     = (cnt_inc == LAST);

   // In Philips mode the bit sampled on the LRCLK edge is the previous LSB.
   always_comb begin
      state_d  = state_q;
      start    = 1'b0;
      done     = 1'b0;
      short_w  = 1'b0;
      shift_en = 1'b0;
      unique case (state_q)
         PRIME: state_d = HUNT;
         HUNT, PAD: start = edge_det;
         SHIFT: begin
            if (edge_det && !(last && !LJ)) begin
               short_w = 1'b1;
               start   = 1'b1;
            end else begin
               shift_en = 1'b1;
               done     = last;
               start    = edge_det;
               if (last && !edge_det) state_d = PAD;
            end
         end
         default: state_d = PRIME;
      endcase
      if (start) state_d = SHIFT;
   end

   always_ff @(posedge i2s_bclk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= PRIME;
         lrclk_q   <= 1'b0;
         ch_q      <= CH_LEFT;
         sh_q      <= '0;
         cnt_q     <= '0;
         rx_data   <= '0;
         rx_ch     <= CH_LEFT;
         rx_valid  <= 1'b0;
         rx_toggle <= 1'b0;
         word_err  <= 1'b0;
         err_count <= '0;
         locked    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lrclk_q  <= i2s_lrclk;
         rx_valid <= done;
         word_err <= short_w;
         if (shift_en || (start && LJ)) sh_q <= sh_in[I2S_WIDTH-2:0];
         if (start) begin
            ch_q  <= i2s_lrclk;
            cnt_q <= LJ ? CW'(1) : '0;
         end else if (shift_en) begin
            cnt_q <= cnt_inc;
         end
         if (done) begin
            rx_data   <= sh_in;
            rx_ch     <= ch_q;
            rx_toggle <= ~rx_toggle;
         end
         if (short_w) begin
            err_count <= ERR_CNT_W'(sat_inc(32'(err_count), 32'(ERR_MAX)));
            locked    <= 1'b0;
         end else if (done) begin
            locked <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// Self-checking bench for i2s_rx_frontend: slot-level stream model
// for Philips and left-justified framing, errors and reset.
module tb_i2s_rx_frontend;
   import i2s_pkg::*;

   localparam int W    = 24;
   localparam int CW   = 8;
   localparam int EMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic lr  = 1'b0;
   logic sd  = 1'b0;

   logic [W-1:0]  d0_data, d1_data;
   logic          d0_ch, d0_valid, d0_tog, d0_err, d0_lock;
   logic          d1_ch, d1_valid, d1_tog, d1_err, d1_lock;
   logic [CW-1:0] d0_cnt, d1_cnt;

   always #5 clk = ~clk;

   i2s_rx_frontend #(
      .I2S_WIDTH(W), .FORMAT(FMT_I2S), .ERR_CNT_W(CW)
   ) dut0 (
      .i2s_bclk(clk), .sys_rst(rst), .i2s_lrclk(lr), .i2s_data(sd),
      .rx_data(d0_data), .rx_ch(d0_ch), .rx_valid(d0_valid),
      .rx_toggle(d0_tog), .word_err(d0_err), .err_count(d0_cnt),
      .locked(d0_lock)
   );

   i2s_rx_frontend #(
      .I2S_WIDTH(W), .FORMAT(FMT_LJ), .ERR_CNT_W(CW)
   ) dut1 (
      .i2s_bclk(clk), .sys_rst(rst), .i2s_lrclk(lr), .i2s_data(sd),
      .rx_data(d1_data), .rx_ch(d1_ch), .rx_valid(d1_valid),
      .rx_toggle(d1_tog), .word_err(d1_err), .err_count(d1_cnt),
      .locked(d1_lock)
   );

   bit            sel = 1'b0;
   logic [W-1:0]  m_data;
   logic          m_ch, m_valid, m_tog, m_err, m_lock;
   logic [CW-1:0] m_cnt;

   assign m_data  = sel ? d1_data  : d0_data;
   assign m_ch    = sel ? d1_ch    : d0_ch;
   assign m_valid = sel ? d1_valid : d0_valid;
   assign m_tog   = sel ? d1_tog   : d0_tog;
   assign m_err   = sel ? d1_err   : d0_err;
   assign m_lock  = sel ? d1_lock  : d0_lock;
   assign m_cnt   = sel ? d1_cnt   : d0_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   logic [W-1:0] got_d[$], exp_d[$];
   logic         got_c[$], exp_c[$];
   int           got_t[$], exp_t[$];
   int           err_seen, tog_bad, stab_bad, lock_bad, exp_err;
   bit           exp_lock;
   logic [W-1:0] prev_d;
   logic         prev_c, prev_t;

   int           sl_len[$];
   logic [31:0]  sl_val[$];

   // Records every handed-off word and flags CDC/locked contract breaks.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (m_valid) begin
            got_d.push_back(m_data);
            got_c.push_back(m_ch);
            got_t.push_back(cyc);
            if (m_tog === prev_t) tog_bad++;
            if (m_lock !== 1'b1) lock_bad++;
         end else if (m_tog !== prev_t || m_data !== prev_d || m_ch !== prev_c) begin
            stab_bad++;
         end
         if (m_err) begin
            err_seen++;
            if (m_lock !== 1'b0) lock_bad++;
         end
         prev_d = m_data;
         prev_c = m_ch;
         prev_t = m_tog;
      end
   end

   task automatic drive(input logic l, input logic d);
      @(negedge clk);
      lr = l;
      sd = d;
      cyc++;
   endtask

   task automatic do_reset(input logic lvl);
      mon_en = 1'b0;
      rst = 1'b1;
      lr = lvl;
      sd = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic start_mon(input int s);
      sel = (s != 0);
      #1;
      got_d.delete(); got_c.delete(); got_t.delete();
      exp_d.delete(); exp_c.delete(); exp_t.delete();
      err_seen = 0; tog_bad = 0; stab_bad = 0; lock_bad = 0;
      exp_err = 0; exp_lock = 1'b0;
      prev_d = m_data;
      prev_c = m_ch;
      prev_t = m_tog;
      mon_en = 1'b1;
   endtask

   // Expands the slot table into per-bclk LRCLK/data and the expected words.
   task automatic play(input int fmt, input int stop_at);
      int total, s, off, lat, base;
      logic ch;
      bit sl[];
      bit sq[];
      total = 4;
      foreach (sl_len[j]) total += sl_len[j];
      sl = new[total];
      sq = new[total];
      foreach (sq[k]) sq[k] = 1'($urandom);
      off = (fmt == FMT_LJ) ? 0 : 1;
      lat = (fmt == FMT_LJ) ? W - 1 : W;
      base = cyc + 1;
      s = 0;
      ch = ~lr;
      foreach (sl_len[j]) begin
         for (int i = 0; i < sl_len[j]; i++) begin
            sl[s+i] = ch;
            sq[s+off+i] = sl_val[j][31-i];
         end
         if (sl_len[j] >= W) begin
            exp_d.push_back(sl_val[j][31 -: W]);
            exp_c.push_back(ch);
            exp_t.push_back(base + s + lat);
         end else begin
            exp_err++;
         end
         exp_lock = (sl_len[j] >= W);
         s += sl_len[j];
         ch = ~ch;
      end
      for (int k = s; k < total; k++) sl[k] = ch;
      for (int k = 0; k < total; k++) begin
         if (stop_at > 0 && k == stop_at) break;
         drive(sl[k], sq[k]);
      end
      if (stop_at == 0) repeat (2) @(negedge clk);
   endtask

   task automatic test_stream(input string name, input int fmt,
                              input bit rst_first, input logic lvl);
      int ec;
      if (rst_first) begin
         do_reset(lvl);
         start_mon(fmt);
      end
      play(fmt, 0);
      checks++;
      if (got_d.size() != exp_d.size()) begin
         errors++;
         $display("FAIL %s word_count: got %0d expected %0d", name, got_d.size(), exp_d.size());
      end
      foreach (exp_d[i]) if (i < got_d.size()) begin
         checks++;
         if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i] || got_t[i] != exp_t[i]) begin
            errors++;
            $display("FAIL %s word%0d: got %h ch%b @%0d expected %h ch%b @%0d", name, i,
                     got_d[i], got_c[i], got_t[i], exp_d[i], exp_c[i], exp_t[i]);
         end
      end
      checks++;
      if (err_seen != exp_err) begin
         errors++;
         $display("FAIL %s word_err_pulses: got %0d expected %0d", name, err_seen, exp_err);
      end
      ec = (exp_err > EMAX) ? EMAX : exp_err;
      checks++;
      if (m_cnt !== CW'(ec)) begin
         errors++;
         $display("FAIL %s err_count: got %0d expected %0d", name, m_cnt, ec);
      end
      checks++;
      if (m_lock !== exp_lock) begin
         errors++;
         $display("FAIL %s locked: got %b expected %b", name, m_lock, exp_lock);
      end
      checks++;
      if (m_tog !== 1'(exp_d.size())) begin
         errors++;
         $display("FAIL %s rx_toggle: got %b expected %b", name, m_tog, 1'(exp_d.size()));
      end
      checks++;
      if (tog_bad + stab_bad + lock_bad != 0) begin
         errors++;
         $display("FAIL %s contract: toggle %0d stability %0d locked %0d (expected 0)",
                  name, tog_bad, stab_bad, lock_bad);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      lr = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({d0_data, d0_ch, d0_valid, d0_tog, d0_err, d0_cnt, d0_lock} !== '0) begin
         errors++;
         $display("FAIL reset_i2s: got %h expected 0",
                  {d0_data, d0_ch, d0_valid, d0_tog, d0_err, d0_cnt, d0_lock});
      end
      checks++;
      if ({d1_data, d1_ch, d1_valid, d1_tog, d1_err, d1_cnt, d1_lock} !== '0) begin
         errors++;
         $display("FAIL reset_lj: got %h expected 0",
                  {d1_data, d1_ch, d1_valid, d1_tog, d1_err, d1_cnt, d1_lock});
      end
   endtask

   task automatic test_stereo32;
      sl_len.delete(); sl_val.delete();
      sl_len = '{32, 32, 32, 32, 32, 32};
      sl_val.push_back({24'hABCDEF, 8'($urandom)});
      sl_val.push_back({24'h123456, 8'($urandom)});
      repeat (4) sl_val.push_back($urandom);
      test_stream("stereo32", FMT_I2S, 1'b1, 1'b1);
   endtask

   task automatic test_exact24;
      sl_len.delete(); sl_val.delete();
      sl_len = '{24, 24, 24, 24, 24, 24};
      sl_val.push_back({24'h800001, 8'($urandom)});
      sl_val.push_back({24'h7FFFFE, 8'($urandom)});
      repeat (4) sl_val.push_back($urandom);
      test_stream("exact24", FMT_I2S, 1'b1, 1'b1);
   endtask

   task automatic test_lj;
      sl_len.delete(); sl_val.delete();
      sl_len = '{32, 32, 32, 32};
      sl_val.push_back({24'h5A5A5A, 8'($urandom)});
      repeat (3) sl_val.push_back($urandom);
      test_stream("lj32", FMT_LJ, 1'b1, 1'b1);
   endtask

   task automatic test_short;
      sl_len.delete(); sl_val.delete();
      sl_len = '{32, 10, 32, 32};
      repeat (4) sl_val.push_back($urandom);
      test_stream("short10", FMT_I2S, 1'b1, 1'b1);
   endtask

   task automatic test_static_sat;
      do_reset(1'b1);
      start_mon(FMT_I2S);
      repeat (40) drive(1'b1, 1'($urandom));
      checks++;
      if (got_d.size() != 0 || err_seen != 0 || m_lock !== 1'b0 || m_tog !== 1'b0) begin
         errors++;
         $display("FAIL static_lrclk: got words %0d errs %0d locked %b toggle %b expected 0 0 0 0",
                  got_d.size(), err_seen, m_lock, m_tog);
      end
      sl_len.delete(); sl_val.delete();
      repeat (300) begin
         sl_len.push_back(3);
         sl_val.push_back($urandom);
      end
      test_stream("saturate", FMT_I2S, 1'b0, 1'b1);
   endtask

   task automatic test_midreset;
      do_reset(1'b0);
      start_mon(FMT_I2S);
      sl_len.delete(); sl_val.delete();
      sl_len = '{32, 32, 32};
      repeat (3) sl_val.push_back($urandom);
      play(FMT_I2S, 52);
      mon_en = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({d0_data, d0_ch, d0_valid, d0_tog, d0_err, d0_cnt, d0_lock} !== '0) begin
         errors++;
         $display("FAIL midreset_async: got %h expected 0",
                  {d0_data, d0_ch, d0_valid, d0_tog, d0_err, d0_cnt, d0_lock});
      end
      do_reset(lr);
      start_mon(FMT_I2S);
      repeat (30) drive(lr, 1'($urandom));
      checks++;
      if (got_d.size() != 0 || err_seen != 0) begin
         errors++;
         $display("FAIL midreset_idle: got words %0d errs %0d expected 0 0",
                  got_d.size(), err_seen);
      end
      sl_len.delete(); sl_val.delete();
      sl_len = '{32, 32};
      repeat (2) sl_val.push_back($urandom);
      test_stream("after_reset", FMT_I2S, 1'b0, lr);
   endtask

   task automatic test_random;
      for (int f = 0; f < 2; f++) begin
         sl_len.delete(); sl_val.delete();
         repeat (40) begin
            if ($urandom_range(0, 3) == 0) sl_len.push_back($urandom_range(1, W - 1));
            else sl_len.push_back($urandom_range(W, 32));
            sl_val.push_back($urandom);
         end
         test_stream(f ? "random_lj" : "random_i2s", f, 1'b1, 1'($urandom));
      end
   endtask

   initial begin
      test_reset();
      test_stereo32();
      test_exact24();
      test_lj();
      test_short();
      test_static_sat();
      test_midreset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
